// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and shared-memory-side signals for mem_port_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [1:0]      err;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;
  logic            sel;

  modport slave (
    input  req, we, addr, wdata, mem_rdata, mem_ack,
    output gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, sel
  );

  modport master (
    output req, we, addr, wdata, mem_rdata, mem_ack,
    input  gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single shared memory port with an
// ack timeout. Every output is a register; FSM state is exposed on state_o.
module mem_port_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]       state_o
);

  // Handshake: a requester holds req high (level) until it sees its one-cycle
  // done pulse; err coincides with done on timeout. mem_req is held until
  // mem_ack (a one-cycle pulse) or the timer expires, whichever comes first.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          sel_q, sel_d;
  logic [7:0]    timer_q, timer_d;
  logic          last_owner_q, last_owner_d;

  logic          owner_w;
  logic [7:0]    timer_inc;

  // A lone request wins outright; a tie goes to whoever did not own last.
  always_comb begin
    if (bus.req == 2'b11) owner_w = ~last_owner_q;
    else                  owner_w = bus.req[1];
  end

  assign timer_inc = timer_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          mem_we_d    = owner_w ? bus.we[1] : bus.we[0];
          mem_addr_d  = owner_w ? bus.addr[AW +: AW] : bus.addr[0 +: AW];
          mem_wdata_d = owner_w ? bus.wdata[DW +: DW] : bus.wdata[0 +: DW];
          mem_req_d   = 1'b1;
          gnt_d       = owner_w ? 2'b10 : 2'b01;
          sel_d       = owner_w;
          timer_d     = 8'd0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // sel_q holds the owner for the whole access.
        if (bus.mem_ack) begin
          rdata_d      = bus.mem_rdata;
          mem_req_d    = 1'b0;
          gnt_d        = 2'b00;
          done_d       = sel_q ? 2'b10 : 2'b01;
          last_owner_d = sel_q;
          state_d      = ST_RESP;
        end else if (timer_inc == TIMEOUT_W) begin
          rdata_d      = '0;
          mem_req_d    = 1'b0;
          gnt_d        = 2'b00;
          done_d       = sel_q ? 2'b10 : 2'b01;
          err_d        = sel_q ? 2'b10 : 2'b01;
          last_owner_d = sel_q;
          timer_d      = timer_inc;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_RESP: begin
        sel_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        gnt_d     = 2'b00;
        sel_d     = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      sel_q        <= 1'b0;
      timer_q      <= 8'd0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sel       = sel_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): single access, ignored ack,
// timeout, ack-vs-timeout race, reset mid-access and round-robin alternation.
module tb_mem_port_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;
  int         n_cmp;
  int         n_fail;

  mem_port_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every step drives and samples 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req       = 2'b00;
    bus.we        = 2'b00;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_gnt[0] = 2'b01;
    exp_gnt[1] = 2'b10;
    exp_gnt[2] = 2'b01;
    exp_gnt[3] = 2'b10;
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();

    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_done", bus.done, 2'b00);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    tick();

    // single fetch read, ack three cycles after mem_req
    bus.req  = 2'b01;
    bus.we   = 2'b00;
    bus.addr = {32'h0000_0999, 32'h0000_0100};
    tick();
    check("rd_mem_req", bus.mem_req, 1'b1);
    check("rd_gnt", bus.gnt, 2'b01);
    check("rd_sel", bus.sel, 1'b0);
    check("rd_mem_addr", bus.mem_addr, 32'h100);
    check("rd_mem_we", bus.mem_we, 1'b0);
    check("rd_state", state, S_BUSY);
    bus.addr = {32'h0000_0999, 32'h0000_0200};
    tick();
    check("rd_addr_frozen", bus.mem_addr, 32'h100);
    tick();
    check("rd_req_held", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("rd_done", bus.done, 2'b01);
    check("rd_err", bus.err, 2'b00);
    check("rd_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("rd_mem_req_drop", bus.mem_req, 1'b0);
    check("rd_gnt_drop", bus.gnt, 2'b00);
    check("rd_state_resp", state, S_RESP);
    bus.mem_ack = 1'b0;
    bus.req     = 2'b00;
    tick();
    check("rd_done_pulse", bus.done, 2'b00);
    check("rd_state_idle", state, S_IDLE);

    // stray ack in IDLE
    bus.mem_ack = 1'b1;
    tick();
    check("stray_mem_req", bus.mem_req, 1'b0);
    check("stray_done", bus.done, 2'b00);
    check("stray_state", state, S_IDLE);
    bus.mem_ack = 1'b0;

    // data write with ack withheld: times out after 4 BUSY cycles
    bus.req   = 2'b10;
    bus.we    = 2'b10;
    bus.wdata = {32'h1234_5678, 32'h0000_AAAA};
    tick();
    check("to_gnt", bus.gnt, 2'b10);
    check("to_sel", bus.sel, 1'b1);
    check("to_mem_we", bus.mem_we, 1'b1);
    check("to_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    tick();
    tick();
    tick();
    check("to_req_cycle4", bus.mem_req, 1'b1);
    check("to_done_early", bus.done, 2'b00);
    tick();
    check("to_mem_req_drop", bus.mem_req, 1'b0);
    check("to_done", bus.done, 2'b10);
    check("to_err", bus.err, 2'b10);
    check("to_rdata", bus.rdata, 32'h0);
    check("to_sel_resp", bus.sel, 1'b1);
    bus.req = 2'b00;
    bus.we  = 2'b00;
    tick();
    check("to_err_pulse", bus.err, 2'b00);
    check("to_sel_idle", bus.sel, 1'b0);

    // ack lands in the same cycle the timer expires: ack wins
    bus.req = 2'b01;
    tick();
    check("race_gnt", bus.gnt, 2'b01);
    tick();
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    check("race_done", bus.done, 2'b01);
    check("race_err", bus.err, 2'b00);
    check("race_rdata", bus.rdata, 32'hCAFE_F00D);
    bus.mem_ack = 1'b0;
    bus.req     = 2'b00;
    tick();

    // reset in BUSY for requester 1 (last owner is now 0)
    bus.req = 2'b10;
    tick();
    check("rb_gnt", bus.gnt, 2'b10);
    tick();
    rst_n = 1'b0;
    #1;
    check("rb_gnt_clr", bus.gnt, 2'b00);
    check("rb_mem_req_clr", bus.mem_req, 1'b0);
    check("rb_sel_clr", bus.sel, 1'b0);
    check("rb_mem_addr_clr", bus.mem_addr, 32'h0);
    check("rb_state_clr", state, S_IDLE);
    bus.req = 2'b11;
    tick();
    check("rb_done_none", bus.done, 2'b00);
    rst_n = 1'b1;

    // both requesting from reset: grants alternate 0,1,0,1
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("rr_gnt_%0d", g), bus.gnt, exp_gnt[g]);
      check($sformatf("rr_sel_%0d", g), bus.sel, exp_gnt[g][1]);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h5000_0000 + 32'(g);
      tick();
      check($sformatf("rr_done_%0d", g), bus.done, exp_gnt[g]);
      check($sformatf("rr_rdata_%0d", g), bus.rdata, 32'h5000_0000 + 32'(g));
      bus.mem_ack = 1'b0;
      tick();
      check($sformatf("rr_gap_%0d", g), bus.mem_req, 1'b0);
    end
    bus.req = 2'b00;
    tick();
    tick();
    check("end_idle", state, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DW, default 32, data width of the shared port and of both requesters.
REQ-002 Parameter AW, default 32, address width of the shared port and of both requesters.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles the arbiter waits for mem_ack; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  2  per-requester access request; bit 0 = fetch, bit 1 = data; level, held until done.
REQ-007 we  input  2  per-requester write enable, 1 = write, 0 = read.
REQ-008 addr  input  2*AW  requester i address at bits [i*AW +: AW].
REQ-009 wdata  input  2*DW  requester i write data at bits [i*DW +: DW].
REQ-010 gnt  output  2  one-hot owner indication; high while requester i owns the port.
REQ-011 done  output  2  one-cycle completion pulse to requester i.
REQ-012 err  output  2  one-cycle timeout pulse to requester i, coincident with done.
REQ-013 rdata  output  DW  read data captured from mem_rdata; valid only in the done cycle.
REQ-014 mem_req  output  1  shared-port request, held until ack or timeout.
REQ-015 mem_we  output  1  shared-port write enable.
REQ-016 mem_addr  output  AW  shared-port address.
REQ-017 mem_wdata  output  DW  shared-port write data.
REQ-018 mem_rdata  input  DW  shared-port read data, valid with mem_ack.
REQ-019 mem_ack  input  1  shared-port completion, one cycle.
REQ-020 sel  output  1  select for the shared-port 2:1 MUX; 1 = requester 1.

Function
REQ-021 FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-022 IDLE: req==0 -> stay; else grant per REQ-023, capture owner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req=1, gnt[owner]=1, sel=owner, load timer=0, go BUSY.
REQ-023 Arbitration round-robin: single request wins; both set -> requester != last_owner wins.
REQ-024 Latency: req seen high at edge N -> mem_req and gnt high from cycle N+1.
REQ-025 BUSY: mem_req, mem_we, mem_addr, mem_wdata, sel constant; requester input changes ignored.
REQ-026 BUSY and mem_ack=1 -> capture mem_rdata into rdata, mem_req=0, gnt=0, done[owner]=1, last_owner=owner, go RESP.
REQ-027 BUSY and mem_ack=0: timer increments; timer reaching TIMEOUT -> mem_req=0, gnt=0, done[owner]=1, err[owner]=1, rdata=0, last_owner=owner, go RESP.
REQ-028 mem_ack and timeout in same cycle -> ack wins, err=0.
REQ-029 RESP: one cycle; done/err pulse visible; sel holds owner; next state IDLE with done=err=0, sel=0; req not sampled in RESP.
REQ-030 Requester drops req in the cycle after done; still-high req in IDLE is treated as a new request.
REQ-031 mem_ack in IDLE or RESP ignored, no state change.
REQ-032 Minimum issue spacing: done at cycle M -> next mem_req no earlier than M+2.
REQ-033 gnt never has both bits set; done/err never asserted for a non-owner.

Reset
REQ-034 rst_n low asynchronously forces IDLE, gnt=0, done=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, sel=0, timer=0, last_owner=1 (fetch wins first tie).
REQ-035 Reset in BUSY aborts the access with no done/err pulse; first request after release arbitrates as from power-up.

Verification
REQ-036 req=2'b01, we0=0, addr0=0x100, ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> sel=0, mem_addr=0x100, done=2'b01 one cycle, rdata=0xDEADBEEF.
REQ-037 req=2'b11 from reset, held after each done -> grants alternate 0,1,0,1; gnt never 2'b11.
REQ-038 req=2'b10, we1=1, wdata1=0x12345678, mem_ack withheld, TIMEOUT=4 -> mem_req drops after 4 BUSY cycles, done=err=2'b10, rdata=0.
REQ-039 mem_ack pulsed in IDLE with req=0 -> no mem_req, no done, state IDLE.
REQ-040 rst_n low mid-BUSY for requester 1 -> all outputs 0 immediately; then req=2'b11 -> requester 0 granted first.
REQ-041 mem_ack coincident with timer reaching TIMEOUT -> done=1, err=0, rdata=mem_rdata.
